// File: rtl/serial_sub4.sv
// Bit-serial two's-complement subtractor D = A - B, one full-subtractor step per cycle.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-2:0] res;
    logic [CNTW-1:0]  cnt;
    logic             br;

    logic             a0;
    logic             b0;
    logic             dbit;
    logic             nbr;
    logic [WIDTH-1:0] cat;
    logic             accept;

    assign a0     = ra[0];
    assign b0     = rb[0];
    assign dbit   = a0 ^ b0 ^ br;
    assign nbr    = (~a0 & b0) | (~(a0 ^ b0) & br);
    // cat is the result after this cycle's bit lands in the MSB; its low bit drops out of res
    assign cat    = {dbit, res};
    assign accept = start && (state == IDLE || state == DONE);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        ra    <= A;
                        rb    <= B;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    res <= cat[WIDTH-1:1];
                    br  <= nbr;
                    cnt <= cnt + CNTW'(1);
                    if (cnt == LAST) begin
                        D     <= cat;
                        Bout  <= nbr;
`ifdef SERIAL_SUB_OVF_EN
                        // borrow into MSB xor borrow out of MSB
                        ovf   <= br ^ nbr;
`endif
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
